mem_port_arbiter: RTL and testbench

Shares a single unified memory bus port between instruction fetch (IF stage) and the MEM-stage load/store path of the RV32ICMFA pipeline. It arbitrates between the two requesters and runs one bus transaction at a time. It drives stall outputs that freeze the IF and MEM pipeline registers until each access completes. Data accesses have priority; a starvation counter guarantees forward progress for fetch.

---
 rtl/mem_port_arbiter.sv | 131 +++++++++++++
 tb/tb_mem_port_arbiter.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// Shares one memory bus port between instruction fetch and the load/store path.
// Data requests win ties; fetch is forced through after STARVE_LIMIT consecutive losses.
module mem_port_arbiter #(
  parameter int DATA_WIDTH   = 32,
  parameter int ADDR_WIDTH   = 32,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    i_req,
  input  logic [ADDR_WIDTH-1:0]   i_addr,
  output logic                    i_ready,
  output logic [DATA_WIDTH-1:0]   i_rdata,
  input  logic                    d_req,
  input  logic                    d_we,
  input  logic [DATA_WIDTH/8-1:0] d_wstrb,
  input  logic [ADDR_WIDTH-1:0]   d_addr,
  input  logic [DATA_WIDTH-1:0]   d_wdata,
  output logic                    d_ready,
  output logic [DATA_WIDTH-1:0]   d_rdata,
  output logic                    bus_req,
  output logic                    bus_we,
  output logic [DATA_WIDTH/8-1:0] bus_wstrb,
  output logic [ADDR_WIDTH-1:0]   bus_addr,
  output logic [DATA_WIDTH-1:0]   bus_wdata,
  input  logic                    bus_gnt,
  input  logic                    bus_rvalid,
  input  logic [DATA_WIDTH-1:0]   bus_rdata,
  output logic                    stall_f,
  output logic                    stall_m
);
  localparam int         STRB_WIDTH = DATA_WIDTH / 8;
  localparam logic [3:0] STARVE_MAX = 4'(STARVE_LIMIT);

  typedef enum logic [1:0] {S_IDLE, S_ADDR, S_RESP, S_DONE} state_t;

  state_t                  r_state;
  state_t                  w_state_next;
  logic                    r_owner_d;   // 0 = fetch owns the bus, 1 = data
  logic                    w_grant;
  logic                    w_grant_d;
  logic [3:0]              r_starve_cnt;
  logic [3:0]              w_starve_next;
  logic                    r_bus_we;
  logic [STRB_WIDTH-1:0]   r_bus_wstrb;
  logic [ADDR_WIDTH-1:0]   r_bus_addr;
  logic [DATA_WIDTH-1:0]   r_bus_wdata;
  logic [DATA_WIDTH-1:0]   r_i_rdata;
  logic [DATA_WIDTH-1:0]   r_d_rdata;

  always_comb begin
    w_state_next  = r_state;
    w_grant       = 1'b0;
    w_grant_d     = 1'b0;
    w_starve_next = r_starve_cnt;
    case (r_state)
      S_IDLE: begin
        w_grant = i_req | d_req;
        if (i_req && d_req && (r_starve_cnt != STARVE_MAX)) begin
          w_grant_d     = 1'b1;
          w_starve_next = (r_starve_cnt < STARVE_MAX) ? r_starve_cnt + 4'd1 : STARVE_MAX;
        end else begin
          w_grant_d     = d_req & ~i_req;
          w_starve_next = 4'd0;
        end
        if (w_grant) w_state_next = S_ADDR;
      end
      S_ADDR:  if (bus_gnt) w_state_next = S_RESP;
      S_RESP:  if (bus_rvalid) w_state_next = S_DONE;
      S_DONE:  w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= S_IDLE;
      r_starve_cnt <= 4'd0;
      r_owner_d    <= 1'b0;
    end else begin
      r_state      <= w_state_next;
      r_starve_cnt <= w_starve_next;
      if (w_grant) r_owner_d <= w_grant_d;
    end
  end

  // Command is captured once at grant and held steady for the whole address phase.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_bus_we    <= 1'b0;
      r_bus_wstrb <= '0;
      r_bus_addr  <= '0;
      r_bus_wdata <= '0;
    end else if (w_grant) begin
      if (w_grant_d) begin
        r_bus_we    <= d_we;
        r_bus_wstrb <= d_wstrb;
        r_bus_addr  <= d_addr;
        r_bus_wdata <= d_wdata;
      end else begin
        r_bus_we    <= 1'b0;
        r_bus_wstrb <= '0;
        r_bus_addr  <= i_addr;
        r_bus_wdata <= '0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_i_rdata <= '0;
      r_d_rdata <= '0;
    end else if ((r_state == S_RESP) && bus_rvalid) begin
      if (r_owner_d) r_d_rdata <= bus_rdata;
      else           r_i_rdata <= bus_rdata;
    end
  end

  assign bus_req   = (r_state == S_ADDR);
  assign bus_we    = r_bus_we;
  assign bus_wstrb = r_bus_wstrb;
  assign bus_addr  = r_bus_addr;
  assign bus_wdata = r_bus_wdata;
  assign i_ready   = (r_state == S_DONE) & ~r_owner_d;
  assign d_ready   = (r_state == S_DONE) & r_owner_d;
  assign i_rdata   = r_i_rdata;
  assign d_rdata   = r_d_rdata;
  assign stall_f   = i_req & ~i_ready;
  assign stall_m   = d_req & ~d_ready;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: table-driven single transactions, directed corner
// sequences, then random traffic checked against a transaction-level reference model.
module tb_mem_port_arbiter;
  localparam int LIMIT = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        i_req, d_req, d_we;
  logic [31:0] i_addr, d_addr, d_wdata;
  logic [3:0]  d_wstrb;
  logic        i_ready, d_ready;
  logic [31:0] i_rdata, d_rdata;
  logic        bus_req, bus_we, bus_gnt, bus_rvalid;
  logic [3:0]  bus_wstrb;
  logic [31:0] bus_addr, bus_wdata, bus_rdata;
  logic        stall_f, stall_m;

  always #5 clk = ~clk;

  mem_port_arbiter #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .STARVE_LIMIT(LIMIT)) dut (
    .clk(clk), .rst_n(rst_n),
    .i_req(i_req), .i_addr(i_addr), .i_ready(i_ready), .i_rdata(i_rdata),
    .d_req(d_req), .d_we(d_we), .d_wstrb(d_wstrb), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_ready(d_ready), .d_rdata(d_rdata),
    .bus_req(bus_req), .bus_we(bus_we), .bus_wstrb(bus_wstrb), .bus_addr(bus_addr),
    .bus_wdata(bus_wdata), .bus_gnt(bus_gnt), .bus_rvalid(bus_rvalid), .bus_rdata(bus_rdata),
    .stall_f(stall_f), .stall_m(stall_m)
  );

  typedef struct {
    logic        is_d;
    logic        we;
    logic [3:0]  wstrb;
    logic [31:0] addr;
    logic [31:0] wdata;
    int          gnt_dly;
    int          rv_dly;
    logic [31:0] rdata;
    int          exp_lat;
    logic        exp_we;
    logic [3:0]  exp_wstrb;
    logic [31:0] exp_wdata;
  } vec_t;

  int          n_tests = 0;
  int          n_fail  = 0;
  logic [31:0] last_i, last_d;
  vec_t        vecs [4];
  bit          exp_seq [10];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    i_req = 0; i_addr = 0; d_req = 0; d_we = 0; d_wstrb = 0; d_addr = 0; d_wdata = 0;
    bus_gnt = 0; bus_rvalid = 0; bus_rdata = 0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    last_i = 0;
    last_d = 0;
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    int cyc, addr_cnt, resp_cnt;
    bit in_resp, seen;
    i_req = !v.is_d; d_req = v.is_d; i_addr = v.addr; d_addr = v.addr;
    d_we = v.we; d_wstrb = v.wstrb; d_wdata = v.wdata;
    bus_gnt = 0; bus_rvalid = 0; bus_rdata = v.rdata;
    cyc = 0; addr_cnt = 0; resp_cnt = 0; in_resp = 0; seen = 0;
    while (!seen && cyc < 40) begin
      @(negedge clk);
      cyc++;
      if (bus_req) begin
        addr_cnt++;
        check($sformatf("v%0d bus_addr", idx), bus_addr, v.addr);
        check($sformatf("v%0d bus_we", idx), bus_we, v.exp_we);
        check($sformatf("v%0d bus_wstrb", idx), bus_wstrb, v.exp_wstrb);
        check($sformatf("v%0d bus_wdata", idx), bus_wdata, v.exp_wdata);
      end
      if (in_resp) resp_cnt++;
      if (v.is_d ? d_ready : i_ready) begin
        seen = 1;
        if (v.is_d) last_d = v.rdata; else last_i = v.rdata;
        check($sformatf("v%0d latency", idx), cyc, v.exp_lat);
        check($sformatf("v%0d i_rdata", idx), i_rdata, last_i);
        check($sformatf("v%0d d_rdata", idx), d_rdata, last_d);
        check($sformatf("v%0d other ready", idx), v.is_d ? i_ready : d_ready, 1'b0);
        check($sformatf("v%0d bus_req in done", idx), bus_req, 1'b0);
        check($sformatf("v%0d addr cycles", idx), addr_cnt, v.gnt_dly + 1);
      end else begin
        check($sformatf("v%0d stall", idx), v.is_d ? stall_m : stall_f, 1'b1);
      end
      bus_gnt = bus_req && (addr_cnt > v.gnt_dly);
      bus_rvalid = in_resp && (resp_cnt > v.rv_dly);
      if (bus_rvalid) in_resp = 0;
      if (bus_gnt) in_resp = 1;
    end
    check($sformatf("v%0d ready seen", idx), seen, 1'b1);
    // Request is still held across the completion cycle; it must not be issued again.
    bus_gnt = 0; bus_rvalid = 0;
    @(negedge clk);
    check($sformatf("v%0d ready one cycle", idx), v.is_d ? d_ready : i_ready, 1'b0);
    check($sformatf("v%0d no reissue", idx), bus_req, 1'b0);
    $display("[TB] vec %0d %s addr=0x%0h done in %0d cycles", idx, v.is_d ? "data" : "fetch", v.addr, cyc);
    i_req = 0; d_req = 0;
    @(negedge clk);
  endtask

  task automatic run_random(input int n_cycles);
    int          phase;  // 0 none, 1 await grant, 2 await response, 3 completion due
    int          starve, n_txn;
    bit          own_d, after_done, exp_ir, exp_dr, exp_bq;
    logic        exp_we;
    logic [3:0]  exp_strb;
    logic [31:0] exp_addr, exp_wdata, exp_data;
    phase = 0; starve = 0; n_txn = 0; own_d = 0; after_done = 0;
    exp_we = 0; exp_strb = 0; exp_addr = 0; exp_wdata = 0; exp_data = 0;
    for (int c = 0; c < n_cycles; c++) begin
      @(negedge clk);
      exp_ir = (phase == 3) && !own_d;
      exp_dr = (phase == 3) && own_d;
      check("rnd i_ready", i_ready, exp_ir);
      check("rnd d_ready", d_ready, exp_dr);
      if (phase == 3) begin
        if (own_d) last_d = exp_data; else last_i = exp_data;
        check("rnd bus_req in done", bus_req, 1'b0);
        $display("[TB] rnd txn %0d %s data=0x%08h", n_txn, own_d ? "data" : "fetch", exp_data);
        n_txn++;
        phase = 0;
        after_done = 1;
      end else if (phase == 0) begin
        exp_bq = !after_done && (i_req || d_req);
        check("rnd bus_req idle", bus_req, exp_bq);
        if (exp_bq) begin
          if (i_req && d_req) begin
            if (starve < LIMIT) begin own_d = 1; starve++; end
            else begin own_d = 0; starve = 0; end
          end else begin
            own_d = d_req;
            starve = 0;
          end
          exp_addr  = own_d ? d_addr : i_addr;
          exp_we    = own_d ? d_we : 1'b0;
          exp_strb  = own_d ? d_wstrb : 4'h0;
          exp_wdata = own_d ? d_wdata : 32'h0;
          phase = 1;
        end else if (!after_done) begin
          starve = 0;
        end
        after_done = 0;
      end
      if (phase == 1) begin
        check("rnd bus_req addr", bus_req, 1'b1);
        check("rnd bus_addr", bus_addr, exp_addr);
        check("rnd bus_we", bus_we, exp_we);
        check("rnd bus_wstrb", bus_wstrb, exp_strb);
        check("rnd bus_wdata", bus_wdata, exp_wdata);
      end else if (phase == 2) begin
        check("rnd bus_req resp", bus_req, 1'b0);
      end
      check("rnd i_rdata hold", i_rdata, last_i);
      check("rnd d_rdata hold", d_rdata, last_d);
      // Requesters: a new command only starts when idle or on the completion cycle.
      if (!i_req || exp_ir) begin
        i_req  = ($urandom_range(0, 2) != 0);
        i_addr = $urandom & 32'h0000_FFFC;
      end
      if (!d_req || exp_dr) begin
        d_req   = ($urandom_range(0, 2) != 0);
        d_we    = $urandom_range(0, 1);
        d_wstrb = 4'($urandom_range(0, 15));
        d_addr  = $urandom & 32'h0003_FFFC;
        d_wdata = $urandom;
      end
      bus_gnt    = ($urandom_range(0, 1) == 1);
      bus_rvalid = ($urandom_range(0, 2) == 0);
      bus_rdata  = $urandom;
      if (phase == 2 && bus_rvalid) begin
        phase = 3;
        exp_data = bus_rdata;
      end else if (phase == 1 && bus_gnt) begin
        phase = 2;
      end
      #1;
      check("rnd stall_f", stall_f, i_req && !exp_ir);
      check("rnd stall_m", stall_m, d_req && !exp_dr);
    end
    check("rnd progress", n_txn > 100, 1'b1);
  endtask

  initial begin
    int  n_g, tmo;
    bit  in_resp;

    vecs[0] = '{1'b0, 1'b0, 4'h0, 32'h0000_0100, 32'h0, 0, 0, 32'h0000_0013, 3, 1'b0, 4'h0, 32'h0};
    vecs[1] = '{1'b1, 1'b1, 4'hF, 32'h0000_2000, 32'hDEAD_BEEF, 2, 0, 32'hAAAA_5555, 5, 1'b1, 4'hF, 32'hDEAD_BEEF};
    vecs[2] = '{1'b1, 1'b0, 4'h0, 32'h0000_3004, 32'h1234_5678, 1, 3, 32'hCAFE_F00D, 7, 1'b0, 4'h0, 32'h1234_5678};
    vecs[3] = '{1'b0, 1'b1, 4'hF, 32'h0000_0104, 32'hFFFF_FFFF, 0, 2, 32'h00A0_0093, 5, 1'b0, 4'h0, 32'h0};
    exp_seq = '{1, 1, 1, 1, 0, 1, 1, 1, 1, 0};

    do_reset();
    check("reset bus_req", bus_req, 1'b0);
    check("reset bus_addr", bus_addr, 32'h0);
    check("reset bus_we", bus_we, 1'b0);
    check("reset bus_wstrb", bus_wstrb, 4'h0);
    check("reset bus_wdata", bus_wdata, 32'h0);
    check("reset i_ready", i_ready, 1'b0);
    check("reset d_ready", d_ready, 1'b0);
    check("reset i_rdata", i_rdata, 32'h0);
    check("reset d_rdata", d_rdata, 32'h0);

    for (int k = 0; k < 4; k++) run_vec(vecs[k], k);

    // Spurious response and grant while idle must be ignored.
    bus_rvalid = 1; bus_rdata = 32'h55; bus_gnt = 1;
    repeat (2) begin
      @(negedge clk);
      check("spurious i_ready", i_ready, 1'b0);
      check("spurious d_ready", d_ready, 1'b0);
      check("spurious bus_req", bus_req, 1'b0);
      check("spurious i_rdata", i_rdata, last_i);
      check("spurious d_rdata", d_rdata, last_d);
    end
    $display("[TB] spurious rvalid in idle done");
    bus_rvalid = 0; bus_gnt = 0;

    // Reset while the response is outstanding.
    d_req = 1; d_we = 0; d_addr = 32'h3000; bus_gnt = 1;
    @(negedge clk);
    check("rstresp bus_req addr", bus_req, 1'b1);
    @(negedge clk);
    check("rstresp bus_req resp", bus_req, 1'b0);
    bus_gnt = 0;
    #1 rst_n = 0; d_req = 0;
    #1;
    check("rstresp bus_addr", bus_addr, 32'h0);
    check("rstresp bus_req", bus_req, 1'b0);
    check("rstresp i_rdata", i_rdata, 32'h0);
    check("rstresp d_rdata", d_rdata, 32'h0);
    check("rstresp stall_m", stall_m, 1'b0);
    @(negedge clk);
    rst_n = 1; bus_rvalid = 1; bus_rdata = 32'h77;
    repeat (3) begin
      @(negedge clk);
      check("rstresp late d_ready", d_ready, 1'b0);
      check("rstresp late d_rdata", d_rdata, 32'h0);
      bus_rvalid = 0;
    end
    $display("[TB] reset during response done");

    // Starvation: both requesters held, data re-requests back to back.
    do_reset();
    i_req = 1; i_addr = 32'h400; d_req = 1; d_addr = 32'h800;
    n_g = 0; tmo = 0; in_resp = 0;
    while (n_g < 10 && tmo < 200) begin
      @(negedge clk);
      tmo++;
      if (i_ready || d_ready) begin
        check($sformatf("starve grant %0d d_ready", n_g), d_ready, exp_seq[n_g]);
        check($sformatf("starve grant %0d i_ready", n_g), i_ready, !exp_seq[n_g]);
        $display("[TB] starve grant %0d -> %s", n_g, d_ready ? "data" : "fetch");
        n_g++;
      end
      bus_rvalid = in_resp;
      in_resp = bus_req;
      bus_gnt = bus_req;
    end
    check("starve grants", n_g, 10);

    do_reset();
    run_random(3000);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
